// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//                input bit per clock, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] adj;
  logic             accept;
  logic             last_shift;

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign last_shift = (cnt_q == CNT_W'(1));

  // Add-3 correction on every digit in parallel ahead of the shift.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      assign adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? (acc_q[4*k +: 4] + 4'd3)
                                                       : acc_q[4*k +: 4];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_SHIFT;
      S_SHIFT: if (last_shift) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    bcd_out   = acc_q;
    ovf       = ovf_q;
  end

  // Datapath next-state; the bit leaving the top digit is worth 10^DIGITS.
  always_comb begin
    bin_d = bin_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (accept) begin
      bin_d = bin_in;
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = CNT_W'(BIN_W);
    end else if (state_q == S_SHIFT) begin
      acc_d = {adj[ACC_W-2:0], bin_q[BIN_W-1]};
      ovf_d = ovf_q | adj[ACC_W-1];
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bin_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Directed self-checking bench for bin2bcd_seq (three configs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: BIN_W=8, DIGITS=3
  logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_ovf;
  logic [7:0]  a_bin = '0;
  logic [11:0] a_bcd;
  // Instance B: BIN_W=8, DIGITS=2
  logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_ovf;
  logic [7:0]  b_bin = '0;
  logic [7:0]  b_bcd;
  // Instance C: BIN_W=16, DIGITS=5
  logic        c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0, c_ovf;
  logic [15:0] c_bin = '0;
  logic [19:0] c_bcd;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .nrst(nrst), .in_valid(a_iv), .in_ready(a_ir), .bin_in(a_bin),
    .out_valid(a_ov), .out_ready(a_or), .bcd_out(a_bcd), .ovf(a_ovf));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .nrst(nrst), .in_valid(b_iv), .in_ready(b_ir), .bin_in(b_bin),
    .out_valid(b_ov), .out_ready(b_or), .bcd_out(b_bcd), .ovf(b_ovf));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
    .clk(clk), .nrst(nrst), .in_valid(c_iv), .in_ready(c_ir), .bin_in(c_bin),
    .out_valid(c_ov), .out_ready(c_or), .bcd_out(c_bcd), .ovf(c_ovf));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic digits_ok(input logic [19:0] v, input int n);
    for (int k = 0; k < n; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic conv_a(input logic [7:0] v, input logic [11:0] exp, input logic exp_ovf);
    int lat;
    check("a_ready_before", a_ir, 1);
    a_bin = v; a_iv = 1'b1;
    step();
    a_iv = 1'b0;
    lat = 0;
    while (!a_ov && lat < 40) begin step(); lat++; end
    check("a_latency", lat, 8);
    check("a_bcd", a_bcd, exp);
    check("a_ovf", a_ovf, exp_ovf);
    check("a_digits", digits_ok({8'h0, a_bcd}, 3), 1);
    a_or = 1'b1;
    step();
    a_or = 1'b0;
    check("a_release", {a_ov, a_ir}, 2'b01);
  endtask

  task automatic conv_b(input logic [7:0] v, input logic [7:0] exp, input logic exp_ovf);
    int lat;
    b_bin = v; b_iv = 1'b1;
    step();
    b_iv = 1'b0;
    lat = 0;
    while (!b_ov && lat < 40) begin step(); lat++; end
    check("b_latency", lat, 8);
    check("b_bcd", b_bcd, exp);
    check("b_ovf", b_ovf, exp_ovf);
    b_or = 1'b1;
    step();
    b_or = 1'b0;
    check("b_release", {b_ov, b_ir}, 2'b01);
  endtask

  task automatic conv_c(input logic [15:0] v, input logic [19:0] exp, input logic exp_ovf);
    int lat;
    c_bin = v; c_iv = 1'b1;
    step();
    c_iv = 1'b0;
    lat = 0;
    while (!c_ov && lat < 60) begin step(); lat++; end
    check("c_latency", lat, 16);
    check("c_bcd", c_bcd, exp);
    check("c_ovf", c_ovf, exp_ovf);
    c_or = 1'b1;
    step();
    c_or = 1'b0;
    check("c_release", {c_ov, c_ir}, 2'b01);
  endtask

  initial begin
    int lat;
    int bp_bad;
    logic [11:0] ref_bcd;

    // Reset state
    nrst = 1'b0;
    step(); step();
    check("rst_in_ready", a_ir, 1);
    check("rst_out_valid", a_ov, 0);
    check("rst_bcd", a_bcd, 0);
    check("rst_ovf", a_ovf, 0);
    nrst = 1'b1;
    step();

    // 8-bit, 3 digits
    conv_a(8'd0,   12'h000, 1'b0);
    conv_a(8'd99,  12'h099, 1'b0);
    conv_a(8'd100, 12'h100, 1'b0);
    conv_a(8'd255, 12'h255, 1'b0);

    // 8-bit, 2 digits: truncation mod 100
    conv_b(8'd99,  8'h99, 1'b0);
    conv_b(8'd100, 8'h00, 1'b1);
    conv_b(8'd255, 8'h55, 1'b1);

    // 16-bit, 5 digits
    conv_c(16'd65535, 20'h65535, 1'b0);
    conv_c(16'd10000, 20'h10000, 1'b0);

    // Backpressure with a stray in_valid while busy
    a_bin = 8'd37; a_iv = 1'b1;
    step();
    a_iv = 1'b0;
    lat = 0;
    while (!a_ov && lat < 40) begin step(); lat++; end
    check("bp_latency", lat, 8);
    a_bin = 8'd99; a_iv = 1'b1;
    bp_bad = 0;
    repeat (20) begin
      step();
      if (!(a_ov === 1'b1 && a_bcd === 12'h037 && a_ir === 1'b0)) bp_bad++;
    end
    check("bp_hold", bp_bad, 0);
    a_or = 1'b1;
    step();
    a_or = 1'b0; a_iv = 1'b0;
    check("bp_release", {a_ov, a_ir}, 2'b01);
    check("bp_keep_bcd", a_bcd, 12'h037);
    step();
    check("bp_no_accept", a_ir, 1);

    // Asynchronous reset mid-conversion
    a_bin = 8'd200; a_iv = 1'b1;
    step();
    a_iv = 1'b0;
    step(); step(); step();
    nrst = 1'b0;
    #1;
    check("midrst_ready_valid", {a_ir, a_ov}, 2'b10);
    check("midrst_bcd", a_bcd, 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    step();
    conv_a(8'd42, 12'h042, 1'b0);

    // All 256 inputs against a decimal reference
    for (int v = 0; v < 256; v++) begin
      ref_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      conv_a(8'(v), ref_bcd, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
